wb_commit: RTL



---
 rtl/wb_commit.sv | 101 ++++++++++
 1 files changed

// File: rtl/wb_commit.sv
// In-order writeback/commit stage: tracks dispatched instructions by tag,
// captures out-of-order completions and retires them to the register file in program order.
module wb_commit #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alloc_en,
    input  logic [4:0]      alloc_rd,
    input  logic            alloc_wen,
    output logic [AW-1:0]   alloc_tag,
    output logic            full,
    output logic            empty,
    input  logic            cmpl_valid,
    input  logic [AW-1:0]   cmpl_tag,
    input  logic [XLEN-1:0] cmpl_data,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            wb_en,
    input  logic            flush
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [AW-1:0]    widx;
    logic [AW-1:0]    ridx;
    logic             ptr_eq;
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] done;
    logic [DEPTH-1:0] wen_q;
    logic [4:0]       rd_q   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic             do_alloc;
    logic             do_cmpl;
    logic             commit;

    assign widx   = wptr[AW-1:0];
    assign ridx   = rptr[AW-1:0];
    assign ptr_eq = (widx == ridx);

    // Status is forced to its idle view while reset is asserted.
    assign full      = rst_n & ptr_eq & (wptr[AW] != rptr[AW]);
    assign empty     = ~rst_n | (ptr_eq & (wptr[AW] == rptr[AW]));
    assign alloc_tag = rst_n ? widx : '0;

    assign do_alloc = alloc_en & ~full & ~flush;
    assign do_cmpl  = cmpl_valid & vld[cmpl_tag] & ~done[cmpl_tag] & ~flush;
    assign commit   = rst_n & ~flush & vld[ridx] & done[ridx];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            vld  <= '0;
            done <= '0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (commit) begin
                vld[ridx] <= 1'b0;
                rptr      <= rptr + PTR_ONE;
            end
            if (do_cmpl) begin
                done[cmpl_tag] <= 1'b1;
            end
            // Allocation is applied last so it wins on a shared index.
            if (do_alloc) begin
                vld[widx]  <= 1'b1;
                done[widx] <= 1'b0;
                wptr       <= wptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_alloc) begin
            rd_q[widx]  <= alloc_rd;
            wen_q[widx] <= alloc_wen & (alloc_rd != 5'd0);
        end
        if (do_cmpl) begin
            data_q[cmpl_tag] <= cmpl_data;
        end
    end

    assign wb_en = commit;

    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (commit) begin
            rf_wen   = wen_q[ridx];
            rf_waddr = rd_q[ridx];
            rf_wdata = data_q[ridx];
        end
    end

endmodule
